ili9341_display_model: RTL

- Display-side responder for the ILI9341 4-wire SPI link: SPI mode 0 slave with a D/C line. It decodes the command/data byte stream into column/page window settings and pixel writes.
- Used as the bench "panel" for the display driver, and as an on-chip frame-capture sink that feeds a framebuffer RAM.
- Pixel writes leave as an address/data/strobe triple sized for a 320x240 RGB565 buffer.

---
 rtl/ili9341_display_model_pkg.sv | 19 +
 rtl/ili9341_display_model_if.sv | 31 +++
 rtl/ili9341_display_model_spi_byte_rx.sv | 56 +++++
 rtl/ili9341_display_model.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ili9341_display_model_pkg.sv
// Shared opcodes, decoder states and default panel geometry for the ILI9341 panel model.
package ili9341_pkg;

  localparam int DEFAULT_COLS = 240;
  localparam int DEFAULT_ROWS = 320;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    PARAMS,
    CASET,
    PASET,
    RAMWR
  } dec_state_t;

endpackage

// File: rtl/ili9341_display_model_if.sv
// SPI link into the panel model plus its decoded command/param/pixel outputs.
interface ili9341_display_model_if #(
  parameter int ADDR_W = 17
);

  logic              tftChipSelect;
  logic              tftSck;
  logic              tftMosi;
  logic              dataCtrl;
  logic              pixelWriteEn;
  logic [ADDR_W-1:0] pixelAddr;
  logic [15:0]       pixelData;
  logic              cmdValid;
  logic [7:0]        cmdByte;
  logic              paramValid;
  logic [7:0]        paramByte;
  logic              frameDone;

  modport master (
    output tftChipSelect, tftSck, tftMosi, dataCtrl,
    input  pixelWriteEn, pixelAddr, pixelData, cmdValid, cmdByte,
           paramValid, paramByte, frameDone
  );

  modport slave (
    input  tftChipSelect, tftSck, tftMosi, dataCtrl,
    output pixelWriteEn, pixelAddr, pixelData, cmdValid, cmdByte,
           paramValid, paramByte, frameDone
  );

endinterface

// File: rtl/ili9341_display_model_spi_byte_rx.sv
// SPI mode 0 byte receiver: 2-flop synchronisers, SCK rising-edge detect, MSB-first shifter.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  input  logic       dc,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       byteIsData
);

  logic [1:0] sck_s, mosi_s, cs_s, dc_s;
  logic       sck_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       rise;

  assign rise = sck_s[1] & ~sck_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s      <= '0;
      mosi_s     <= '0;
      cs_s       <= '1;
      dc_s       <= '0;
      sck_d      <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      byteValid  <= 1'b0;
      byteData   <= '0;
      byteIsData <= 1'b0;
    end else begin
      sck_s     <= {sck_s[0], sck};
      mosi_s    <= {mosi_s[0], mosi};
      cs_s      <= {cs_s[0], cs_n};
      dc_s      <= {dc_s[0], dc};
      sck_d     <= sck_s[1];
      byteValid <= 1'b0;
      // Deselect drops any partial byte without emitting it.
      if (cs_s[1]) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shift   <= {shift[5:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byteValid  <= 1'b1;
          byteData   <= {shift, mosi_s[1]};
          byteIsData <= dc_s[1];
        end
      end
    end
  end

endmodule

// File: rtl/ili9341_display_model.sv
// ILI9341 panel model: decodes the SPI byte stream into window settings and pixel writes.
module ili9341_display_model
  import ili9341_pkg::*;
#(
  parameter int COLS   = DEFAULT_COLS,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ADDR_W = 17
) (
  input logic                    CLK_I,
  input logic                    RST_I,
  ili9341_display_model_if.slave bus
);

  localparam logic [15:0] COLS_W = 16'(COLS);
  localparam logic [15:0] ROWS_W = 16'(ROWS);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;

  spi_byte_rx u_rx (
    .clk        (CLK_I),
    .rst        (RST_I),
    .sck        (bus.tftSck),
    .mosi       (bus.tftMosi),
    .cs_n       (bus.tftChipSelect),
    .dc         (bus.dataCtrl),
    .byteValid  (byte_valid),
    .byteData   (byte_data),
    .byteIsData (byte_is_data)
  );

  dec_state_t        state;
  logic [15:0]       sc, ec, sp, ep, col, page;
  logic [1:0]        arg_cnt;
  logic [23:0]       arg_buf;
  logic              half;
  logic [7:0]        hi;
  logic              pix_we, cmd_v, par_v, frame_done;
  logic [ADDR_W-1:0] pix_addr;
  logic [15:0]       pix_data;
  logic [7:0]        cmd_b, par_b;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      sc         <= '0;
      ec         <= COLS_W - 16'd1;
      sp         <= '0;
      ep         <= ROWS_W - 16'd1;
      col        <= '0;
      page       <= '0;
      arg_cnt    <= '0;
      arg_buf    <= '0;
      half       <= 1'b0;
      hi         <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      cmd_v      <= 1'b0;
      cmd_b      <= '0;
      par_v      <= 1'b0;
      par_b      <= '0;
      frame_done <= 1'b0;
    end else begin
      cmd_v      <= 1'b0;
      par_v      <= 1'b0;
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid) begin
        if (!byte_is_data) begin
          // Commands abort whatever is in progress; a half pixel or short window update is dropped.
          cmd_v   <= 1'b1;
          cmd_b   <= byte_data;
          arg_cnt <= '0;
          half    <= 1'b0;
          case (byte_data)
            CMD_CASET: state <= CASET;
            CMD_PASET: state <= PASET;
            CMD_RAMWR: begin
              state <= RAMWR;
              col   <= sc;
              page  <= sp;
            end
            default:   state <= PARAMS;
          endcase
        end else begin
          case (state)
            CASET, PASET: begin
              arg_buf <= {arg_buf[15:0], byte_data};
              arg_cnt <= arg_cnt + 2'd1;
              if (arg_cnt == 2'd3) begin
                if (state == CASET) begin
                  sc <= arg_buf[23:8];
                  ec <= {arg_buf[7:0], byte_data};
                end else begin
                  sp <= arg_buf[23:8];
                  ep <= {arg_buf[7:0], byte_data};
                end
                state <= PARAMS;
              end
            end
            RAMWR: begin
              if (!half) begin
                hi   <= byte_data;
                half <= 1'b1;
              end else begin
                half     <= 1'b0;
                pix_data <= {hi, byte_data};
                pix_addr <= ADDR_W'(32'(page) * 32'(COLS) + 32'(col));
                pix_we   <= (col < COLS_W) && (page < ROWS_W);
                // Comparing with >= makes an inverted window collapse to one column/page.
                if (col >= ec) begin
                  col <= sc;
                  if (page >= ep) begin
                    page       <= sp;
                    frame_done <= 1'b1;
                  end else begin
                    page <= page + 16'd1;
                  end
                end else begin
                  col <= col + 16'd1;
                end
              end
            end
            default: begin
              par_v <= 1'b1;
              par_b <= byte_data;
            end
          endcase
        end
      end
    end
  end

  assign bus.pixelWriteEn = pix_we;
  assign bus.pixelAddr    = pix_addr;
  assign bus.pixelData    = pix_data;
  assign bus.cmdValid     = cmd_v;
  assign bus.cmdByte      = cmd_b;
  assign bus.paramValid   = par_v;
  assign bus.paramByte    = par_b;
  assign bus.frameDone    = frame_done;

endmodule
